// File: rtl/key_demux.sv
// key_demux: routes valid/ready beats to the channel whose programmed key matches, one holding register per channel.
// Define KEY_DEMUX_DEFAULT_EN to steer unmatched keys to channel DEF_CH instead of dropping them.
module key_demux #(
    parameter int NR_CH    = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 2,
    parameter int DEF_CH   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NR_CH*KEY_LEN-1:0]   lut,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [KEY_LEN-1:0]         in_key,
    input  logic [DATA_LEN-1:0]        in_data,
    output logic [NR_CH-1:0]           out_valid,
    input  logic [NR_CH-1:0]           out_ready,
    output logic [NR_CH*DATA_LEN-1:0]  out_data,
    output logic [7:0]                 miss_cnt
);

`ifdef KEY_DEMUX_DEFAULT_EN
    localparam logic DEF_EN = 1'b1;
`else
    localparam logic DEF_EN = 1'b0;
`endif
    localparam int DEF_IDX = (DEF_CH >= 0 && DEF_CH < NR_CH) ? DEF_CH : 0;

    logic [NR_CH-1:0]          valid_q, valid_d;
    logic [NR_CH*DATA_LEN-1:0] data_q, data_d;
    logic [7:0]                miss_q, miss_d;
    logic [NR_CH-1:0]          tgt_oh, slot_free, load;
    logic                      hit_any, accept;

    // Scan from the top so the lowest matching channel is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        tgt_oh  = '0;
        for (int n = NR_CH - 1; n >= 0; n--) begin
            if (lut[KEY_LEN*n +: KEY_LEN] == in_key) begin
                tgt_oh    = '0;
                tgt_oh[n] = 1'b1;
                hit_any   = 1'b1;
            end
        end
        if (DEF_EN && !hit_any) begin
            tgt_oh[DEF_IDX] = 1'b1;
        end
    end

    assign slot_free = ~valid_q | out_ready;
    // Without a default channel a miss has nowhere to wait, so it is always taken and dropped.
    assign in_ready  = !rst && ((!hit_any && !DEF_EN) || (|(tgt_oh & slot_free)));
    assign accept    = in_valid && in_ready;
    assign load      = {NR_CH{accept}} & tgt_oh;

    always_comb begin
        valid_d = (valid_q & ~out_ready) | load;
        data_d  = data_q;
        miss_d  = miss_q;
        for (int n = 0; n < NR_CH; n++) begin
            if (load[n]) begin
                data_d[DATA_LEN*n +: DATA_LEN] = in_data;
            end
        end
        if (accept && !hit_any && miss_q != 8'hFF) begin
            miss_d = miss_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            miss_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            miss_q  <= miss_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_key_demux.sv
// Self-checking bench for key_demux: directed scenarios plus randomized traffic against a slot-array reference model.
module tb_key_demux;
    localparam int NR_CH    = 4;
    localparam int KEY_LEN  = 2;
    localparam int DATA_LEN = 2;
    localparam int DEF_CH   = 0;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NR_CH*KEY_LEN-1:0]  lut;
    logic                      in_valid;
    logic                      in_ready;
    logic [KEY_LEN-1:0]        in_key;
    logic [DATA_LEN-1:0]       in_data;
    logic [NR_CH-1:0]          out_valid;
    logic [NR_CH-1:0]          out_ready;
    logic [NR_CH*DATA_LEN-1:0] out_data;
    logic [7:0]                miss_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: one entry per channel plus a miss tally.
    logic                m_valid [NR_CH];
    logic [DATA_LEN-1:0] m_data  [NR_CH];
    int                  m_miss;

    key_demux #(.NR_CH(NR_CH), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .DEF_CH(DEF_CH)) dut (
        .clk(clk), .rst(rst), .lut(lut),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic int find_hit(input logic [KEY_LEN-1:0] k);
        for (int n = 0; n < NR_CH; n++) begin
            if (lut[n*KEY_LEN +: KEY_LEN] == k) return n;
        end
        return -1;
    endfunction

    function automatic int route(input logic [KEY_LEN-1:0] k);
        int h;
        h = find_hit(k);
`ifdef KEY_DEMUX_DEFAULT_EN
        if (h < 0) h = DEF_CH;
`endif
        return h;
    endfunction

    function automatic logic model_ready();
        int t;
        if (rst) return 1'b0;
        t = route(in_key);
        if (t < 0) return 1'b1;
        return !m_valid[t] || out_ready[t];
    endfunction

    function automatic logic [NR_CH-1:0] model_ov();
        logic [NR_CH-1:0] v;
        for (int n = 0; n < NR_CH; n++) v[n] = m_valid[n];
        return v;
    endfunction

    function automatic logic [NR_CH*DATA_LEN-1:0] model_od();
        logic [NR_CH*DATA_LEN-1:0] d;
        for (int n = 0; n < NR_CH; n++) d[n*DATA_LEN +: DATA_LEN] = m_data[n];
        return d;
    endfunction

    task automatic drive(input logic v, input logic [KEY_LEN-1:0] k,
                         input logic [DATA_LEN-1:0] d, input logic [NR_CH-1:0] r);
        in_valid  = v;
        in_key    = k;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick();
        logic rdy;
        int   t;
        logic hit;
        rdy = model_ready();
        t   = route(in_key);
        hit = (find_hit(in_key) >= 0);
        @(posedge clk);
        if (rst) begin
            for (int n = 0; n < NR_CH; n++) begin
                m_valid[n] = 1'b0;
                m_data[n]  = '0;
            end
            m_miss = 0;
        end else begin
            for (int n = 0; n < NR_CH; n++) begin
                if (m_valid[n] && out_ready[n]) m_valid[n] = 1'b0;
            end
            if (in_valid && rdy) begin
                if (t >= 0) begin
                    m_valid[t] = 1'b1;
                    m_data[t]  = in_data;
                end
                if (!hit && m_miss < 255) m_miss++;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lut = '0;
        drive(1'b1, 2'd0, 2'd1, '1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 2'd0, 2'd0, '1);
        checks++;
        if (out_valid !== 4'b0000 || out_data !== 8'h00 || miss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h m=%0d want v=0000 d=00 m=0",
                     out_valid, out_data, miss_cnt);
        end
    endtask

    task automatic test_routing();
        logic [DATA_LEN-1:0] dat [4];
        dat[0] = 2'd1; dat[1] = 2'd2; dat[2] = 2'd3; dat[3] = 2'd0;
        lut = {2'd3, 2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, KEY_LEN'(i), dat[i], 4'b1111);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL route_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 4'(1 << i) || out_data[i*DATA_LEN +: DATA_LEN] !== dat[i] ||
                miss_cnt !== 8'd0) begin
                errors++;
                $display("FAIL route[%0d]: got v=%b d=%h m=%0d want v=%b d=%h m=0",
                         i, out_valid, out_data[i*DATA_LEN +: DATA_LEN], miss_cnt,
                         4'(1 << i), dat[i]);
            end
        end
        drive(1'b0, 2'd0, 2'd0, 4'b1111);
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL route_drain: got %b want 0000", out_valid);
        end
    endtask

    task automatic test_backpressure();
        lut = {2'd3, 2'd2, 2'd1, 2'd0};
        drive(1'b1, 2'd2, 2'd2, 4'b1011);
        tick();
        checks++;
        if (out_valid[2] !== 1'b1 || out_data[5:4] !== 2'd2) begin
            errors++; $display("FAIL bp_first: got v=%b d=%h want v=1 d=2", out_valid[2], out_data[5:4]);
        end
        drive(1'b1, 2'd2, 2'd1, 4'b1011);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall: got in_ready=%b want 0", in_ready);
        end
        tick();
        tick();
        checks++;
        if (out_valid[2] !== 1'b1 || out_data[5:4] !== 2'd2) begin
            errors++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=2", out_valid[2], out_data[5:4]);
        end
        drive(1'b1, 2'd2, 2'd1, 4'b1111);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got in_ready=%b want 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0100 || out_data[5:4] !== 2'd1) begin
            errors++; $display("FAIL bp_swap: got v=%b d=%h want v=0100 d=1", out_valid, out_data[5:4]);
        end
        drive(1'b0, 2'd0, 2'd0, 4'b1111);
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL bp_drain: got %b want 0000", out_valid);
        end
    endtask

    task automatic test_duplicate();
        lut = {2'd1, 2'd2, 2'd1, 2'd0};
        drive(1'b1, 2'd1, 2'd3, 4'b0000);
        tick();
        checks++;
        if (out_valid !== 4'b0010 || out_data[3:2] !== 2'd3) begin
            errors++; $display("FAIL dup_key: got v=%b d=%h want v=0010 d=3", out_valid, out_data[3:2]);
        end
        drive(1'b0, 2'd0, 2'd0, 4'b1111);
        tick();
    endtask

    task automatic test_miss();
        lut = '0;
        drive(1'b1, 2'd2, 2'd3, 4'b1111);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL miss_ready: got %b want 1", in_ready);
        end
        tick();
        checks++;
`ifdef KEY_DEMUX_DEFAULT_EN
        if (out_valid !== 4'(1 << DEF_CH) || miss_cnt !== 8'd1) begin
            errors++; $display("FAIL miss_default: got v=%b m=%0d want v=%b m=1",
                               out_valid, miss_cnt, 4'(1 << DEF_CH));
        end
        drive(1'b1, 2'd2, 2'd1, 4'b1111 & ~4'(1 << DEF_CH));
        tick();
        drive(1'b1, 2'd2, 2'd2, 4'b1111 & ~4'(1 << DEF_CH));
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL miss_blocked: got in_ready=%b want 0", in_ready);
        end
        drive(1'b0, 2'd0, 2'd0, 4'b1111);
        tick();
`else
        if (out_valid !== 4'b0000 || miss_cnt !== 8'd1) begin
            errors++; $display("FAIL miss_drop: got v=%b m=%0d want v=0000 m=1", out_valid, miss_cnt);
        end
`endif
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'd2, DATA_LEN'(i), 4'b1111);
            tick();
        end
        checks++;
        if (miss_cnt !== 8'd255) begin
            errors++; $display("FAIL miss_saturate: got %0d want 255", miss_cnt);
        end
        drive(1'b0, 2'd0, 2'd0, 4'b1111);
        tick();
    endtask

    task automatic test_reset_mid();
        lut = {2'd3, 2'd2, 2'd1, 2'd0};
        drive(1'b1, 2'd1, 2'd1, 4'b0000);
        tick();
        drive(1'b1, 2'd2, 2'd2, 4'b0000);
        tick();
        checks++;
        if (out_valid !== 4'b0110) begin
            errors++; $display("FAIL mid_fill: got %b want 0110", out_valid);
        end
        rst = 1'b1;
        drive(1'b1, 2'd3, 2'd3, 4'b0000);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ready: got %b want 0", in_ready);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, 2'd3, 2'd3, 4'b0000);
        checks++;
        if (out_valid !== 4'b0000 || out_data !== 8'h00 || miss_cnt !== 8'd0) begin
            errors++; $display("FAIL mid_rst_state: got v=%b d=%h m=%0d want 0/00/0",
                               out_valid, out_data, miss_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_resume_ready: got %b want 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 4'b1000 || out_data[7:6] !== 2'd3) begin
            errors++; $display("FAIL mid_resume: got v=%b d=%h want v=1000 d=3", out_valid, out_data[7:6]);
        end
        drive(1'b0, 2'd0, 2'd0, 4'b1111);
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) lut = NR_CH*KEY_LEN'($urandom);
            drive(1'($urandom_range(0, 3) != 0), KEY_LEN'($urandom), DATA_LEN'($urandom),
                  NR_CH'($urandom));
            checks++;
            if (in_ready !== model_ready()) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, model_ready());
            end
            tick();
            checks++;
            if (out_valid !== model_ov() || out_data !== model_od() || miss_cnt !== 8'(m_miss)) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h m=%0d want v=%b d=%h m=%0d",
                         c, out_valid, out_data, miss_cnt, model_ov(), model_od(), m_miss);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int n = 0; n < NR_CH; n++) begin
            m_valid[n] = 1'b0;
            m_data[n]  = '0;
        end
        m_miss    = 0;
        rst       = 1'b1;
        lut       = '0;
        in_valid  = 1'b0;
        in_key    = '0;
        in_data   = '0;
        out_ready = '0;
        @(negedge clk);
        #1;
        test_reset();
        test_routing();
        test_backpressure();
        test_duplicate();
        test_miss();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
